fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined core.
- Replaces the bare PC register plus IF_ID latch with a PC generator, a one-cycle-latency imem request path and a DEPTH-entry prefetch queue.
- Queue entries carry {pc, instr}; decode pops entries through a valid/ready handshake.
- Supports redirect (taken branch/jump) with flush of queued and in-flight fetches.
- Addressing is word-based: sequential PC increments by 1.

---
 rtl/fetch_defs.sv | 23 ++
 rtl/fq_fifo.sv | 75 +++++++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch front end.
//   - Default XLEN and reset PC.
//   - Queue entry layout: {pc, instr}. The pc field is in the upper XLEN bits
//     and the instr field is in the lower XLEN bits.
package fetch_defs;

    localparam int unsigned FQ_XLEN_DEFAULT = 32;
    localparam logic [31:0] FQ_RESET_PC     = 32'h0000_0000;

    // The instruction occupies the low half of an entry.
    localparam int unsigned FQ_INSTR_LSB    = 0;

    // Total width of one queue entry, {pc, instr}.
    function automatic int unsigned fq_entry_w(input int unsigned xlen);
        return 2 * xlen;
    endfunction

    // The PC sits directly above the instruction field.
    function automatic int unsigned fq_pc_lsb(input int unsigned xlen);
        return xlen;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular prefetch buffer that holds DEPTH entries, each W bits wide.
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-high reset
//   flush      drops every entry at the next edge (pointers and count go to 0)
//   push       writes push_data at the tail
//   push_data  entry to write
//   pop        removes the head entry
//   head_data  head entry; zero when the buffer is empty
//   count      number of valid entries, 0..DEPTH
// The caller guarantees that push never happens when the buffer is full, and
// that pop never happens when it is empty.
module fq_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 64,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: every variable written in always_comb gets a default first, so
    // that no path through the block infers a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples values from before the edge, whatever the order of the blocks.
    always_ff @(posedge clock) begin
        if (clear || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset. Nothing reads it while count is
    // zero, and leaving out the reset lets it map to plain RAM or flops
    // without a reset.
    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= push_data;
    end

    // Zero the head output when empty. Stale slots left after a flush or
    // clear are never presented.
    assign head_data = (count_q != '0) ? mem_q[head_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: a PC generator, a one-cycle-latency imem
// request path, and a DEPTH-entry prefetch queue of {pc, instr} entries.
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset; overrides everything else
//   imem_addr    imem word address, the low ADDR_W bits of the fetch PC
//   imem_rd_en   a request is issued this cycle
//   imem_rdata   instruction word, returned the cycle after a request
//   redirect     flush the queue and in-flight fetch, restart at redirect_pc
//   redirect_pc  new fetch PC
//   out_valid    queue head is valid
//   out_ready    decode accepts the head
//   out_pc       PC of the head entry
//   out_instr    instruction of the head entry
//   occupancy    number of valid queue entries
module fetch_queue
    import fetch_defs::*;
#(
    parameter  int unsigned     XLEN     = FQ_XLEN_DEFAULT,
    parameter  int unsigned     ADDR_W   = 8,
    parameter  int unsigned     DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = XLEN'(FQ_RESET_PC),
    localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              clear,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    output logic [CW-1:0]     occupancy
);

    localparam int unsigned ENTRY_W = fq_entry_w(XLEN);
    localparam int unsigned PC_LSB  = fq_pc_lsb(XLEN);

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    pc_q, pc_d;          // PC of the request now in flight
    logic               inflight_q, inflight_d;
    logic               push, pop, credit_ok;
    logic [CW:0]        credit_sum;
    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    // Credits cover queued entries plus the word in flight. The pop in this
    // cycle frees a slot now, so fetch resumes in the same cycle as a pop.
    assign credit_sum = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign credit_ok  = credit_sum < (CW+1)'(DEPTH);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        imem_rd_en = ~clear & ~redirect & credit_ok;
        // A redirect discards the head, so it cannot also count as a pop.
        pop        = out_valid & out_ready & ~redirect & ~clear;
        // In-flight data is dropped in the cycle of a redirect or clear.
        push       = inflight_q & ~redirect & ~clear;
        inflight_d = imem_rd_en;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_rd_en) begin
            fetch_pc_d = fetch_pc_q + XLEN'(1);
            pc_d       = fetch_pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        push_entry                          = '0;
        push_entry[PC_LSB +: XLEN]          = pc_q;
        push_entry[FQ_INSTR_LSB +: XLEN]    = imem_rdata;
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign imem_addr = fetch_pc_q[ADDR_W-1:0];
    assign out_valid = (count != '0);
    assign out_pc    = head_entry[PC_LSB +: XLEN];
    assign out_instr = head_entry[FQ_INSTR_LSB +: XLEN];
    assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (XLEN=32, ADDR_W=8, DEPTH=4, RESET_PC=0).
// The imem model returns 0x100 + address the cycle after a request. For each
// fetch stream, the main process queues the {pc, instr} pairs that decode
// should see. A negedge monitor pops that queue on every accepted head.
module tb_fetch_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear, redirect, out_ready;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  occupancy;

    int   checks   = 0;
    int   failures = 0;
    int   accepts  = 0;
    exp_t exp_q[$];

    fetch_queue #(
        .XLEN   (32),
        .ADDR_W (8),
        .DEPTH  (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    // Synchronous imem: imem[k] = 0x100 + k
    always @(posedge clock) begin
        if (imem_rd_en) imem_rdata <= 32'h100 + {24'h0, imem_addr};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h100 + {24'h0, pc[7:0]};
        return e;
    endfunction

    // Queue the fetch stream that should start at 'start'
    task automatic expect_stream(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(mk(start + 32'(k)));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: on every accepted head, compare with the oldest expected entry
    always @(negedge clock) begin
        if (!clear && !redirect && out_valid && out_ready) begin
            accepts++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_pop: got pc %0h expected no accept", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", {32'h0, out_pc}, {32'h0, e.pc});
                check("sb_instr", {32'h0, out_instr}, {32'h0, e.instr});
            end
        end
    end

    initial begin
        clear       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        tick();
        #1 check("clear_rd_en", 64'(imem_rd_en), 64'd0);
        tick();
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);

        // Free run from reset: first valid two cycles later, one per cycle
        expect_stream(32'h0);
        accepts   = 0;
        clear     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 check("run_valid", 64'(out_valid), (i >= 2) ? 64'd1 : 64'd0);
            tick();
        end
        check("run_accepts", 64'(accepts), 64'd8);

        // Stall from reset: fill to DEPTH, then issue stops
        clear     = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        clear = 1'b0;
        expect_stream(32'h0);
        accepts = 0;
        repeat (8) tick();
        #1;
        check("stall_occ", 64'(occupancy), 64'd4);
        check("stall_rd_en", 64'(imem_rd_en), 64'd0);
        out_ready = 1'b1;
        #1;
        check("release_rd_en", 64'(imem_rd_en), 64'd1);
        check("release_addr", 64'(imem_addr), 64'h4);
        tick();
        out_ready = 1'b0;
        #1;
        check("release_occ", 64'(occupancy), 64'd3);
        check("release_rd_en_off", 64'(imem_rd_en), 64'd0);
        check("release_accepts", 64'(accepts), 64'd1);

        // Redirect with 3 queued and 1 in flight, ready high on a valid head
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        out_ready   = 1'b1;
        expect_stream(32'h40);
        accepts = 0;
        #1 check("redir_rd_en", 64'(imem_rd_en), 64'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("redir_occ", 64'(occupancy), 64'd0);
        check("redir_valid1", 64'(out_valid), 64'd0);
        check("redir_rd_en1", 64'(imem_rd_en), 64'd1);
        check("redir_addr", 64'(imem_addr), 64'h40);
        tick();
        #1 check("redir_valid2", 64'(out_valid), 64'd0);
        tick();
        #1;
        check("redir_valid3", 64'(out_valid), 64'd1);
        check("redir_pc3", 64'(out_pc), 64'h40);
        repeat (3) tick();
        check("redir_accepts", 64'(accepts), 64'd3);

        // Address wrap: imem_addr wraps at 8 bits, PC keeps full width
        redirect    = 1'b1;
        redirect_pc = 32'hFE;
        expect_stream(32'hFE);
        accepts = 0;
        tick();
        redirect = 1'b0;
        #1 check("wrap_addr0", 64'(imem_addr), 64'hFE);
        tick();
        #1 check("wrap_addr1", 64'(imem_addr), 64'hFF);
        tick();
        #1;
        check("wrap_addr2", 64'(imem_addr), 64'h00);
        check("wrap_pc0", 64'(out_pc), 64'hFE);
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        check("wrap_pc2", 64'(out_pc), 64'h100);
        check("wrap_instr2", 64'(out_instr), 64'h100);
        check("wrap_accepts", 64'(accepts), 64'd2);

        // Clear in mid-stream with 2 entries queued
        tick();
        #1 check("mid_occ", 64'(occupancy), 64'd2);
        clear = 1'b1;
        exp_q.delete();
        #1 check("mid_clear_rd_en", 64'(imem_rd_en), 64'd0);
        tick();
        clear     = 1'b0;
        out_ready = 1'b1;
        expect_stream(32'h0);
        accepts = 0;
        #1;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_occ0", 64'(occupancy), 64'd0);
        check("mid_rd_en", 64'(imem_rd_en), 64'd1);
        check("mid_addr", 64'(imem_addr), 64'h0);
        tick();
        tick();
        #1;
        check("mid_valid2", 64'(out_valid), 64'd1);
        check("mid_pc", 64'(out_pc), 64'h0);
        repeat (3) tick();
        check("mid_accepts", 64'(accepts), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
